// File: rtl/apb_responder_pkg.sv
// Shared types and constants for the APB register responder.
package apb_responder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [31:0] ID_DEFAULT = 32'hA5B0_0001;
  localparam int          WAIT_W     = 4;
  localparam int          IDX_OUT_W  = 8;
  localparam logic [7:0]  ERR_MAX    = 8'hFF;

endpackage

// File: rtl/apb_responder_regfile.sv
// Register storage with one synchronous write port and a combinational read port.
// Slot 0 is a read-only identification constant.
module apb_responder_regfile
  import apb_responder_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    IDX_W      = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(ID_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (widx != '0)) begin
      regs[widx] <= wdata;
    end
  end

  assign rdata = (ridx == '0) ? ID_VALUE : regs[ridx];

endmodule

// File: rtl/apb_responder.sv
// APB completer exposing a small register file with programmable wait states,
// decode-error signalling, a write-notify strobe and error/protocol monitors.
module apb_responder
  import apb_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(ID_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [WAIT_W-1:0]     wait_cfg,
  output logic                  wr_pulse,
  output logic [IDX_OUT_W-1:0]  wr_idx,
  output logic [7:0]            err_count,
  output logic                  proto_err
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WAIT_W-1:0]     wait_cnt;

  logic                  setup_fire, complete, abort, idle_penable;
  logic                  respond, commit, dec_err, resp_write;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic [IDX_W-1:0]      idx;
  logic [IDX_OUT_W-1:0]  idx_ext;
  logic [DATA_WIDTH-1:0] reg_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    setup_fire   = (state == IDLE) && psel && !penable;
    idle_penable = (state == IDLE) && penable;
    complete     = (state == ACCESS) && psel && penable && pready;
    abort        = (state == ACCESS) && !psel;
    case (state)
      IDLE:    if (setup_fire) state_next = ACCESS;
      ACCESS:  if (abort || complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A zero-wait transfer must answer on the setup edge, before the latches hold
  // the request, so decode looks at the live bus then and at the latches after.
  always_comb begin
    resp_addr  = setup_fire ? paddr : addr_q;
    resp_write = setup_fire ? pwrite : write_q;
    idx        = resp_addr[IDX_W+1:2];
    dec_err    = (resp_addr[1:0] != 2'b00)
              || ((resp_addr >> (IDX_W + 2)) != '0)
              || (resp_write && (idx == '0));
    respond    = (setup_fire && (wait_cfg == '0))
              || ((state == ACCESS) && psel && !pready && (wait_cnt == WAIT_W'(1)));
    commit     = complete && write_q && !dec_err;
    idx_ext    = '0;
    idx_ext[IDX_W-1:0] = idx;
  end

  apb_responder_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (commit),
    .widx    (idx),
    .wdata   (wdata_q),
    .ridx    (idx),
    .rdata   (reg_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_idx    <= '0;
      err_count <= '0;
      proto_err <= 1'b0;
    end else begin
      wr_pulse <= commit;
      wr_idx   <= commit ? idx_ext : '0;

      if (setup_fire) begin
        addr_q   <= paddr;
        write_q  <= pwrite;
        wdata_q  <= pwdata;
        wait_cnt <= wait_cfg;
      end else if ((state == ACCESS) && psel && !pready && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end

      // Read data is only exposed while pready is high and only for clean reads.
      if (respond) begin
        pready  <= 1'b1;
        pslverr <= dec_err;
        prdata  <= (resp_write || dec_err) ? '0 : reg_rdata;
      end else if (complete || abort) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end

      if (complete && dec_err && (err_count != ERR_MAX)) begin
        err_count <= err_count + 8'd1;
      end

      if (abort || idle_penable) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_responder.sv
// Self-checking bench for apb_responder: directed scenarios plus randomized
// transfers compared against a transaction-level model of the register map.
module tb_apb_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  wait_cfg;
  logic [31:0] prdata;
  logic        pready, pslverr, wr_pulse, proto_err;
  logic [7:0]  wr_idx, err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_total = 0;

  logic [31:0] model_regs [16];
  int          model_err;
  bit          model_proto;

  apb_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .wait_cfg  (wait_cfg),
    .wr_pulse  (wr_pulse),
    .wr_idx    (wr_idx),
    .err_count (err_count),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Legal space is 16 word-aligned slots starting at byte 0; slot 0 is read-only.
  function automatic bit modelErr(input logic [31:0] a, input bit wr);
    return (a % 4 != 0) || (a >= 32'd64) || (wr && (a == 32'd0));
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    int slot;
    slot = int'(a / 4);
    return (slot == 0) ? 32'hA5B0_0001 : model_regs[slot];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    model_err   = 0;
    model_proto = 1'b0;
  endtask

  // Called at a falling edge; performs one full transfer and returns at the
  // falling edge after completion with the bus idle.
  task automatic applyStimulus(input logic [31:0] addr, input bit wr, input logic [31:0] data,
                               input int wcfg, input bit scramble);
    int          cycles;
    bit          seen, err, pulse_exp;
    logic [31:0] exp_rd;
    err       = modelErr(addr, wr);
    exp_rd    = (wr || err) ? 32'd0 : modelRead(addr);
    pulse_exp = wr && !err;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    wait_cfg = 4'(wcfg);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      penable = 1'b1;
      if (scramble) begin
        paddr    = $urandom;
        pwdata   = $urandom;
        wait_cfg = 4'($urandom);
      end
      if (pready === 1'b1) seen = 1'b1;
    end
    checkOutput("ready_latency", 32'(cycles), 32'(wcfg + 1));
    checkOutput("pslverr", {31'd0, pslverr}, {31'd0, err});
    checkOutput("prdata", prdata, exp_rd);
    @(negedge clk);
    if (err) begin
      if (model_err < 255) model_err++;
    end else if (wr) begin
      model_regs[int'(addr / 4)] = data;
    end
    checkOutput("ready_cleared", {30'd0, pready, pslverr}, 32'd0);
    checkOutput("prdata_cleared", prdata, 32'd0);
    checkOutput("wr_pulse", {31'd0, wr_pulse}, {31'd0, pulse_exp});
    checkOutput("wr_idx", {24'd0, wr_idx}, pulse_exp ? addr / 4 : 32'd0);
    checkOutput("err_count", {24'd0, err_count}, 32'(model_err));
    checkOutput("proto_err", {31'd0, proto_err}, {31'd0, model_proto});
    if (wr_pulse === 1'b1) pulse_total++;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic abortTransfer(input logic [31:0] addr, input int wcfg, input int access_cycles);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = 1'b1; pwdata = 32'h1234_5678;
    wait_cfg = 4'(wcfg);
    repeat (access_cycles) begin
      @(negedge clk);
      penable = 1'b1;
      checkOutput("abort_ready_low", {31'd0, pready}, 32'd0);
    end
    @(negedge clk);
    checkOutput("abort_ready_low", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    model_proto = 1'b1;
    checkOutput("abort_ready", {31'd0, pready}, 32'd0);
    checkOutput("abort_no_pulse", {31'd0, wr_pulse}, 32'd0);
    checkOutput("abort_proto", {31'd0, proto_err}, 32'd1);
  endtask

  initial begin
    int          c0, p0, kind, slot;
    logic [31:0] a;
    bit          w;

    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; wait_cfg = '0;
    modelReset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] reset released");
    checkOutput("rst_prdata", prdata, 32'd0);
    checkOutput("rst_flags", {27'd0, pready, pslverr, wr_pulse, proto_err, 1'b0}, 32'd0);
    checkOutput("rst_wr_idx", {24'd0, wr_idx}, 32'd0);
    checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);

    // Zero-wait write then readback.
    applyStimulus(32'h04, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
    @(negedge clk);
    applyStimulus(32'h04, 1'b0, 32'h0, 0, 1'b0);

    // ID register with five wait states.
    applyStimulus(32'h00, 1'b0, 32'h0, 5, 1'b0);

    // Three decode errors.
    applyStimulus(32'h00, 1'b1, 32'h1111_1111, 0, 1'b0);
    applyStimulus(32'h02, 1'b1, 32'h2222_2222, 2, 1'b0);
    applyStimulus(32'h40, 1'b1, 32'h3333_3333, 1, 1'b0);
    checkOutput("err_count_three", {24'd0, err_count}, 32'd3);
    applyStimulus(32'h04, 1'b0, 32'h0, 0, 1'b0);
    applyStimulus(32'h00, 1'b0, 32'h0, 0, 1'b0);

    // Requester drops psel mid-transfer.
    abortTransfer(32'h0C, 4, 2);
    applyStimulus(32'h0C, 1'b0, 32'h0, 0, 1'b0);
    applyStimulus(32'h0C, 1'b1, 32'hCAFE_F00D, 3, 1'b0);

    // Reset pulse in the middle of a write.
    psel = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h5555_AAAA;
    wait_cfg = 4'd3;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    checkOutput("midrst_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("midrst_proto", {31'd0, proto_err}, 32'd0);
    applyStimulus(32'h08, 1'b0, 32'h0, 0, 1'b0);
    applyStimulus(32'h0C, 1'b0, 32'h0, 1, 1'b0);

    // penable without a preceding setup.
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    penable = 1'b0;
    model_proto = 1'b1;
    checkOutput("idle_penable_proto", {31'd0, proto_err}, 32'd1);
    checkOutput("idle_penable_ready", {31'd0, pready}, 32'd0);

    // Ten back-to-back zero-wait writes.
    @(negedge clk);
    c0 = cyc;
    p0 = pulse_total;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(32'(i * 4), 1'b1, $urandom, 0, 1'b0);
    end
    checkOutput("b2b_cycles", 32'(cyc - c0), 32'd20);
    checkOutput("b2b_pulses", 32'(pulse_total - p0), 32'd10);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(32'(i * 4), 1'b0, 32'h0, $urandom_range(0, 3), 1'b1);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      slot = $urandom_range(0, 15);
      w    = 1'($urandom_range(0, 1));
      case (kind)
        0:       a = 32'(slot * 4 + $urandom_range(1, 3));
        1:       a = 32'h40 + 32'($urandom_range(0, 255) * 4);
        2:       a = 32'h8000_0000 | 32'(slot * 4);
        default: a = 32'(slot * 4);
      endcase
      applyStimulus(a, w, $urandom, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drive the error counter into saturation.
    for (int n = 0; n < 260; n++) begin
      applyStimulus(32'h00, 1'b1, $urandom, 0, 1'b0);
    end
    checkOutput("err_saturate", {24'd0, err_count}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_responder.md
APB_RESPONDER -- requirements
Module: apb_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data and register width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count, power of two, 2..256.
REQ-004 SHALL have parameter ID_VALUE, default 32'hA5B0_0001, constant returned by register 0.
REQ-005 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have ports psel, penable, pwrite, input, 1 each, APB requester controls.
REQ-008 SHALL have port paddr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have port pwdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have port prdata, output, DATA_WIDTH, read data, registered.
REQ-011 SHALL have ports pready and pslverr, output, 1 each, registered.
REQ-012 SHALL have port wait_cfg, input, 4, wait states inserted per transfer.
REQ-013 SHALL have ports wr_pulse (output, 1) and wr_idx (output, 8), one-cycle notice of each committed write and its register index.
REQ-014 SHALL have ports err_count (output, 8) and proto_err (output, 1): saturating error counter and sticky protocol-violation flag.

Function
REQ-015 SHALL implement FSM states IDLE and ACCESS.
REQ-016 In IDLE, SHALL detect setup phase (psel=1, penable=0) and then: latch paddr, pwrite and pwdata; load wait counter with wait_cfg; go to ACCESS.
REQ-017 SHALL decode index = paddr[log2(NUM_REGS)+1:2].
REQ-018 SHALL flag a decode error for any of: paddr[1:0] nonzero, address bits above the index nonzero, or a write to index 0.
REQ-019 SHALL assert pready exactly once per transfer, in the (wait_cfg+1)-th cycle after the setup cycle; wait_cfg=0 gives a zero-wait transfer.
REQ-020 Completion is the edge where psel=1, penable=1 and pready=1; at completion, SHALL return to IDLE and drive pready, pslverr and prdata to 0 on that edge.
REQ-021 pslverr SHALL be 1 only while pready=1, and only for a decode-error transfer.
REQ-022 On a read, prdata SHALL carry register contents (index 0 returns ID_VALUE) while pready=1, and SHALL be 0 at all other times and on errored reads.
REQ-023 On an error-free write, SHALL update the register at the completion edge, and SHALL pulse wr_pulse with wr_idx valid in the following cycle.
REQ-024 An errored write SHALL leave all registers unchanged.
REQ-025 SHALL increment err_count at each errored completion and hold it at 255 without wrap.
REQ-026 If psel drops in ACCESS before completion, SHALL abort: no write, no pready, return to IDLE, set proto_err (cleared only by reset).
REQ-027 penable=1 seen in IDLE SHALL be ignored and SHALL set proto_err.
REQ-028 A setup phase on the cycle after completion SHALL be accepted (back-to-back transfers).
REQ-029 wait_cfg SHALL be sampled only at setup; changes mid-transfer SHALL have no effect.
REQ-030 pwdata and paddr SHALL be taken from setup-phase latches, and changes during ACCESS SHALL be ignored.

Reset
REQ-031 While reset_n=0 at an edge, SHALL force: state IDLE, registers 1..NUM_REGS-1 to 0, and all outputs to 0.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer without a write and without setting proto_err.

Structure
REQ-033 Package apb_responder_pkg SHALL hold the state enum and the default ID constant.
REQ-034 Storage plus write-port logic SHALL live in sub-module apb_responder_regfile; decode, FSM and counters SHALL live in the top module.
REQ-035 Target size SHALL be 150-300 RTL lines; the block SHALL contain no behavioural tasks or delays.

Verification
REQ-036 Write 32'hDEAD_BEEF to 0x04, wait_cfg=0, then read 0x04 -> write completes with pready on the first access cycle and pslverr=0; wr_pulse with wr_idx=1; read returns 32'hDEAD_BEEF.
REQ-037 Read 0x00 with wait_cfg=5 -> pready high in the 6th cycle after setup; prdata=32'hA5B0_0001.
REQ-038 Write to 0x00, 0x02 and 0x40 (NUM_REGS=16) -> each returns pslverr=1; registers unchanged; err_count=3.
REQ-039 Drop psel after 2 access cycles with wait_cfg=4 -> no pready, proto_err=1, target register unchanged; the next legal transfer still completes.
REQ-040 Assert reset_n=0 for one cycle mid-write to 0x08 -> register 0x08 reads 0, err_count=0, proto_err=0.
REQ-041 Ten back-to-back writes to 0x04..0x28, wait_cfg=0 -> ten completions on consecutive 2-cycle transfers, ten wr_pulses, wr_idx 1..10.
